// File: rtl/uart_axil_bram_bridge_if.sv
// Bus bundle between the CPU-side AXI4-Lite initiator, the bridge, and the
// UART register file BRAM port. The bridge takes the slave view: it is the
// AXI slave and drives the BRAM port. The master view is the opposite side.
interface uart_axil_bram_bridge_if #(
  parameter int AXI_AW  = 5,
  parameter int BRAM_AW = 3
);
  logic [AXI_AW-1:0]  s_awaddr;
  logic               s_awvalid;
  logic               s_awready;
  logic [31:0]        s_wdata;
  logic [3:0]         s_wstrb;
  logic               s_wvalid;
  logic               s_wready;
  logic [1:0]         s_bresp;
  logic               s_bvalid;
  logic               s_bready;
  logic [AXI_AW-1:0]  s_araddr;
  logic               s_arvalid;
  logic               s_arready;
  logic [31:0]        s_rdata;
  logic [1:0]         s_rresp;
  logic               s_rvalid;
  logic               s_rready;
  logic               bram_en;
  logic [BRAM_AW-1:0] bram_addr;
  logic [3:0]         bram_we;
  logic [31:0]        bram_wdata;
  logic [31:0]        bram_rdata;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready, bram_rdata,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid,
    output bram_en, bram_addr, bram_we, bram_wdata
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready, bram_rdata,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid,
    input  bram_en, bram_addr, bram_we, bram_wdata
  );
endinterface

// File: rtl/uart_axil_bram_bridge.sv
// AXI4-Lite slave to BRAM-port master bridge for the UART register file.
// One transaction in flight at a time with fixed latency; reads and writes
// that contend in IDLE are granted alternately, a read going first after reset.
module uart_axil_bram_bridge #(
  parameter int AXI_AW  = 5,
  parameter int BRAM_AW = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_axil_bram_bridge_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_EN,
    WR_RESP,
    RD_EN,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               last_wr;
  logic [BRAM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         we_q;
  logic [31:0]        rdata_q;

  logic               wr_pend;
  logic               rd_pend;
  logic               grant_wr;
  logic               wr_go;
  logic               rd_go;

  // A write needs AW and W together; under contention the side not served last wins.
  assign wr_pend  = bus.s_awvalid & bus.s_wvalid;
  assign rd_pend  = bus.s_arvalid;
  assign grant_wr = wr_pend & (~rd_pend | ~last_wr);
  assign wr_go    = (state == IDLE) & grant_wr;
  assign rd_go    = (state == IDLE) & rd_pend & ~grant_wr;

  assign bus.s_awready = wr_go;
  assign bus.s_wready  = wr_go;
  assign bus.s_arready = rd_go;

  // Strobes and valids are decoded from the state so they are one-cycle exact;
  // address and write data sit in registers that hold their value when idle.
  assign bus.bram_en    = (state == WR_EN) || (state == RD_EN);
  assign bus.bram_we    = (state == WR_EN) ? we_q : 4'h0;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;
  assign bus.s_bvalid   = (state == WR_RESP);
  assign bus.s_bresp    = 2'b00;
  assign bus.s_rvalid   = (state == RD_RESP);
  assign bus.s_rdata    = rdata_q;
  assign bus.s_rresp    = 2'b00;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: fixed walk through the enable/wait cycles, parked on the response until accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_go) begin
          state_nxt = WR_EN;
        end else if (rd_go) begin
          state_nxt = RD_EN;
        end
      end
      WR_EN:   state_nxt = WR_RESP;
      WR_RESP: if (bus.s_bready) state_nxt = IDLE;
      RD_EN:   state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RD_RESP;
      RD_RESP: if (bus.s_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture request fields at the grant, the registered BRAM read data in RD_WAIT, and arbitration history.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      rdata_q <= '0;
      last_wr <= 1'b1;
    end else begin
      if (wr_go) begin
        addr_q  <= bus.s_awaddr[AXI_AW-1:2];
        wdata_q <= bus.s_wdata;
        we_q    <= bus.s_wstrb;
        last_wr <= 1'b1;
      end else if (rd_go) begin
        addr_q  <= bus.s_araddr[AXI_AW-1:2];
        last_wr <= 1'b0;
      end
      if (state == RD_WAIT) begin
        rdata_q <= bus.bram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_uart_axil_bram_bridge.sv
// Self-checking bench for uart_axil_bram_bridge: a behavioural BRAM with a
// one-cycle registered read, a word-array scoreboard of expected contents,
// and scenario tasks driving directed and randomized transactions.
module tb_uart_axil_bram_bridge;
  localparam int AXI_AW  = 5;
  localparam int BRAM_AW = 3;
  localparam int TMO     = 50;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] init_mem [8];
  logic [31:0] mem      [8];
  logic [31:0] ref_mem  [8];
  logic        mem_load;
  logic [31:0] bram_q;

  uart_axil_bram_bridge_if #(.AXI_AW(AXI_AW), .BRAM_AW(BRAM_AW)) bus ();

  uart_axil_bram_bridge #(.AXI_AW(AXI_AW), .BRAM_AW(BRAM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.bram_rdata = bram_q;

  // BRAM port model: byte-enabled write, read data registered one cycle after enable
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 8; i++) mem[i] <= init_mem[i];
      bram_q <= '0;
    end else if (bus.bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.bram_we[b]) mem[bus.bram_addr][8*b +: 8] <= bus.bram_wdata[8*b +: 8];
      bram_q <= mem[bus.bram_addr];
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (3) nxt();
    rst = 1'b0;
    nxt();
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold);
    int n;
    logic [2:0] w;
    w = addr[4:2];
    bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = strb;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    #1;
    n = 0;
    while (!(bus.s_awready && bus.s_wready) && n < TMO) begin nxt(); n++; end
    checks++;
    if (!(bus.s_awready && bus.s_wready)) begin
      errors++;
      $display("FAIL wr_accept: awready=%0b wready=%0b after %0d cycles, required 1/1",
               bus.s_awready, bus.s_wready, n);
      clear_inputs();
      return;
    end
    nxt();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    checks++;
    if (bus.bram_en !== 1'b1 || bus.bram_we !== strb || bus.bram_addr !== w ||
        bus.bram_wdata !== data || bus.s_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_en: en=%0b we=%h addr=%0d wdata=%h bvalid=%0b, required 1 %h %0d %h 0",
               bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata, bus.s_bvalid, strb, w, data);
    end
    nxt();
    checks++;
    if (bus.bram_en !== 1'b0 || bus.bram_we !== 4'h0 || bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00) begin
      errors++;
      $display("FAIL wr_resp: en=%0b we=%h bvalid=%0b bresp=%0d, required 0 0 1 0",
               bus.bram_en, bus.bram_we, bus.s_bvalid, bus.s_bresp);
    end
    for (int i = 0; i < hold; i++) begin
      nxt();
      checks++;
      if (bus.s_bvalid !== 1'b1 || bus.bram_en !== 1'b0) begin
        errors++;
        $display("FAIL wr_hold: bvalid=%0b en=%0b, required 1 0", bus.s_bvalid, bus.bram_en);
      end
    end
    bus.s_bready = 1'b1;
    nxt();
    bus.s_bready = 1'b0;
    checks++;
    if (bus.s_bvalid !== 1'b0 || bus.bram_addr !== w || bus.bram_wdata !== data) begin
      errors++;
      $display("FAIL wr_done: bvalid=%0b addr=%0d wdata=%h, required 0 %0d %h",
               bus.s_bvalid, bus.bram_addr, bus.bram_wdata, w, data);
    end
    for (int b = 0; b < 4; b++)
      if (strb[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic do_read(input logic [4:0] addr, input int hold);
    int n;
    logic [2:0] w;
    logic [31:0] exp;
    w = addr[4:2];
    bus.s_araddr = addr;
    bus.s_arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.s_arready && n < TMO) begin nxt(); n++; end
    checks++;
    if (!bus.s_arready) begin
      errors++;
      $display("FAIL rd_accept: arready=%0b after %0d cycles, required 1", bus.s_arready, n);
      clear_inputs();
      return;
    end
    nxt();
    bus.s_arvalid = 1'b0;
    checks++;
    if (bus.bram_en !== 1'b1 || bus.bram_we !== 4'h0 || bus.bram_addr !== w || bus.s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_en: en=%0b we=%h addr=%0d rvalid=%0b, required 1 0 %0d 0",
               bus.bram_en, bus.bram_we, bus.bram_addr, bus.s_rvalid, w);
    end
    nxt();
    checks++;
    if (bus.bram_en !== 1'b0 || bus.s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_wait: en=%0b rvalid=%0b, required 0 0", bus.bram_en, bus.s_rvalid);
    end
    nxt();
    exp = ref_mem[w];
    checks++;
    if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== exp || bus.s_rresp !== 2'b00) begin
      errors++;
      $display("FAIL rd_resp: rvalid=%0b rdata=%h rresp=%0d, required 1 %h 0",
               bus.s_rvalid, bus.s_rdata, bus.s_rresp, exp);
    end
    if (hold > 0) begin
      bus.s_arvalid = 1'b1; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      nxt();
      checks++;
      if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== exp || bus.bram_en !== 1'b0 ||
          bus.s_arready !== 1'b0 || bus.s_awready !== 1'b0) begin
        errors++;
        $display("FAIL rd_hold: rvalid=%0b rdata=%h en=%0b arready=%0b awready=%0b, required 1 %h 0 0 0",
                 bus.s_rvalid, bus.s_rdata, bus.bram_en, bus.s_arready, bus.s_awready, exp);
      end
    end
    bus.s_rready = 1'b1;
    nxt();
    bus.s_rready = 1'b0;
    bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    checks++;
    if (bus.s_rvalid !== 1'b0 || bus.s_rdata !== exp) begin
      errors++;
      $display("FAIL rd_done: rvalid=%0b rdata=%h, required 0 %h", bus.s_rvalid, bus.s_rdata, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.bram_en !== 1'b0 || bus.bram_we !== 4'h0 || bus.bram_addr !== '0 ||
        bus.bram_wdata !== '0 || bus.s_bvalid !== 1'b0 || bus.s_rvalid !== 1'b0 ||
        bus.s_rdata !== '0 || bus.s_bresp !== 2'b00 || bus.s_rresp !== 2'b00 ||
        bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0 || bus.s_arready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: en=%0b we=%h addr=%0d wdata=%h bvalid=%0b rvalid=%0b rdata=%h, required all 0",
               bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata, bus.s_bvalid, bus.s_rvalid, bus.s_rdata);
    end
  endtask

  task automatic test_first_read();
    do_read(5'h00, 0);
  endtask

  task automatic test_write_full();
    do_write(5'h04, 32'h0010_0020, 4'hF, 0);
    do_read(5'h04, 0);
  endtask

  task automatic test_write_strobe();
    do_write(5'h00, 32'h00FF_0000, 4'h4, 1);
    do_read(5'h03, 0);
    checks++;
    if (ref_mem[0] !== 32'h02FF_0000 || bus.s_rdata !== 32'h02FF_0000) begin
      errors++;
      $display("FAIL strobe_merge: rdata=%h, required 02ff0000", bus.s_rdata);
    end
  endtask

  task automatic test_wstrb_zero();
    do_write(5'h1D, $urandom, 4'h0, 1);
    do_read(5'h1C, 0);
  endtask

  task automatic test_no_partial();
    bus.s_awaddr = 5'h08; bus.s_awvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      checks++;
      if (bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0 || bus.bram_en !== 1'b0) begin
        errors++;
        $display("FAIL aw_only: awready=%0b wready=%0b en=%0b, required 0 0 0",
                 bus.s_awready, bus.s_wready, bus.bram_en);
      end
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      checks++;
      if (bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0 || bus.bram_en !== 1'b0) begin
        errors++;
        $display("FAIL w_only: awready=%0b wready=%0b en=%0b, required 0 0 0",
                 bus.s_awready, bus.s_wready, bus.bram_en);
      end
    end
    clear_inputs();
    nxt();
  endtask

  // Both sides pending continuously: grants must alternate starting with a read,
  // spaced 4 cycles after a read and 3 cycles after a write.
  task automatic test_arbitration();
    int  cyc, grants, last_cyc, gap;
    bit  last_wr_m, last_was_wr, is_wr, exp_wr;
    logic [31:0] wd;
    do_reset();
    wd = $urandom;
    last_wr_m = 1'b1;
    bus.s_araddr = 5'h08; bus.s_arvalid = 1'b1;
    bus.s_awaddr = 5'h0C; bus.s_wdata = wd; bus.s_wstrb = 4'hF;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    #1;
    cyc = 0; grants = 0; last_cyc = 0; last_was_wr = 1'b0;
    while (grants < 8 && cyc < 100) begin
      if (bus.s_arready && bus.s_awready) begin
        checks++; errors++;
        $display("FAIL arb_both: arready=1 awready=1 at cycle %0d, required one", cyc);
      end else if (bus.s_arready || bus.s_awready) begin
        is_wr = bus.s_awready;
        exp_wr = !last_wr_m;
        checks++;
        if (is_wr !== exp_wr) begin
          errors++;
          $display("FAIL arb_order: grant %0d write=%0b, required write=%0b", grants, is_wr, exp_wr);
        end
        if (grants > 0) begin
          gap = last_was_wr ? 3 : 4;
          checks++;
          if (cyc - last_cyc != gap) begin
            errors++;
            $display("FAIL arb_gap: grant %0d gap=%0d, required %0d", grants, cyc - last_cyc, gap);
          end
        end
        last_wr_m = exp_wr;
        last_was_wr = is_wr;
        last_cyc = cyc;
        grants++;
        if (is_wr) ref_mem[3] = wd;
      end
      if (bus.s_rvalid) begin
        checks++;
        if (bus.s_rdata !== ref_mem[2]) begin
          errors++;
          $display("FAIL arb_rdata: rdata=%h, required %h", bus.s_rdata, ref_mem[2]);
        end
      end
      nxt();
      cyc++;
    end
    bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    checks++;
    if (grants < 8) begin
      errors++;
      $display("FAIL arb_count: grants=%0d, required 8", grants);
    end
    repeat (5) nxt();
    clear_inputs();
    nxt();
    do_read(5'h0C, 0);
  endtask

  task automatic test_rready_hold();
    do_read(5'h08, 5);
  endtask

  task automatic test_reset_mid();
    int n;
    bus.s_araddr = 5'h10; bus.s_arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.s_arready && n < TMO) begin nxt(); n++; end
    checks++;
    if (!bus.s_arready) begin
      errors++;
      $display("FAIL rstmid_accept: arready=0 after %0d cycles, required 1", n);
      clear_inputs();
      return;
    end
    nxt();
    bus.s_arvalid = 1'b0;
    nxt();
    rst = 1'b1;
    nxt();
    checks++;
    if (bus.s_rvalid !== 1'b0 || bus.bram_en !== 1'b0 || bus.bram_addr !== '0 || bus.s_rdata !== '0) begin
      errors++;
      $display("FAIL rstmid_state: rvalid=%0b en=%0b addr=%0d rdata=%h, required 0 0 0 0",
               bus.s_rvalid, bus.bram_en, bus.bram_addr, bus.s_rdata);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      checks++;
      if (bus.s_rvalid !== 1'b0 || bus.bram_en !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet: rvalid=%0b en=%0b, required 0 0", bus.s_rvalid, bus.bram_en);
      end
    end
    do_read(5'h10, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      else
        do_read(5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) init_mem[i] = $urandom;
    init_mem[0] = 32'h021E_0000;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_mem[i];
    mem_load = 1'b1;
    do_reset();
    mem_load = 1'b0;
    test_reset();
    test_first_read();
    test_write_full();
    test_write_strobe();
    test_wstrb_zero();
    test_no_partial();
    test_arbitration();
    test_rready_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
